// File: rtl/uint16_number_entry.sv
// Keypad number-entry controller: accumulates decimal key presses (MSD first)
// into a 16-bit value and hands it off with a valid/ready handshake.
module uint16_number_entry #(
  parameter int MAX_DIGITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        zero,
  input  logic        one,
  input  logic        two,
  input  logic        three,
  input  logic        four,
  input  logic        five,
  input  logic        six,
  input  logic        seven,
  input  logic        eight,
  input  logic        nine,
  input  logic        clear,
  input  logic        enter,
  input  logic        number_ready,
  output logic [15:0] number,
  output logic        number_valid,
  output logic [3:0]  last_digit,
  output logic [2:0]  digit_count,
  output logic        overflow
);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] number_r;
  logic        number_valid_r;
  logic [3:0]  last_digit_r;
  logic [2:0]  digit_count_r;
  logic        overflow_r;
  logic        any_key_prev_r;

  logic [9:0]  digit_keys_s;
  logic        any_key_s;
  logic        key_event_s;
  logic [3:0]  key_count_s;
  logic [3:0]  digit_s;
  logic [19:0] candidate_s;
  logic        reject_s;

  function automatic logic [3:0] count_keys(input logic [9:0] keys);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 10; i++) begin
      cnt = cnt + {3'd0, keys[i]};
    end
    return cnt;
  endfunction

  function automatic logic [3:0] key_index(input logic [9:0] keys);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Key decode and range check for the digit candidate
  always_comb begin
    digit_keys_s = {nine, eight, seven, six, five, four, three, two, one, zero};
    any_key_s    = (|digit_keys_s) | clear | enter;
    key_event_s  = any_key_s & ~any_key_prev_r;
    key_count_s  = count_keys(digit_keys_s);
    digit_s      = key_index(digit_keys_s);
    // 20 bits wide so 6553x*10+9 cannot wrap before the range check
    candidate_s  = ({4'd0, number_r} * 20'd10) + {16'd0, digit_s};
    reject_s     = (candidate_s > 20'd65535) || (digit_count_r == 3'(MAX_DIGITS));
  end

  // Entry FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= RELEASE;
      number_r       <= 16'd0;
      number_valid_r <= 1'b0;
      last_digit_r   <= 4'd0;
      digit_count_r  <= 3'd0;
      overflow_r     <= 1'b0;
      any_key_prev_r <= 1'b0;
    end else begin
      any_key_prev_r <= any_key_s;
      if (clear) begin
        state_r        <= RELEASE;
        number_r       <= 16'd0;
        number_valid_r <= 1'b0;
        last_digit_r   <= 4'd0;
        digit_count_r  <= 3'd0;
        overflow_r     <= 1'b0;
      end else begin
        case (state_r)
          ENTRY: begin
            if (key_event_s) begin
              if (enter) begin
                if (digit_count_r != 3'd0) begin
                  number_valid_r <= 1'b1;
                  state_r        <= DONE;
                end else begin
                  state_r <= RELEASE;
                end
              end else if (key_count_s == 4'd1) begin
                if ((digit_s == 4'd0) && (digit_count_r == 3'd0)) begin
                  number_r <= number_r;
                end else if (reject_s) begin
                  overflow_r <= 1'b1;
                end else begin
                  number_r      <= candidate_s[15:0];
                  digit_count_r <= digit_count_r + 3'd1;
                  last_digit_r  <= digit_s;
                end
                state_r <= RELEASE;
              end else begin
                state_r <= RELEASE;
              end
            end else begin
              state_r <= ENTRY;
            end
          end
          RELEASE: begin
            if (!any_key_s) begin
              state_r <= ENTRY;
            end else begin
              state_r <= RELEASE;
            end
          end
          DONE: begin
            if (number_valid_r && number_ready) begin
              number_r       <= 16'd0;
              number_valid_r <= 1'b0;
              last_digit_r   <= 4'd0;
              digit_count_r  <= 3'd0;
              overflow_r     <= 1'b0;
              state_r        <= RELEASE;
            end else begin
              state_r <= DONE;
            end
          end
          default: begin
            state_r <= RELEASE;
          end
        endcase
      end
    end
  end

  assign number       = number_r;
  assign number_valid = number_valid_r;
  assign last_digit   = last_digit_r;
  assign digit_count  = digit_count_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_uint16_number_entry.sv
// Directed self-checking bench for uint16_number_entry.
module tb_uint16_number_entry;

  logic        clk;
  logic        rst;
  logic [9:0]  keys;
  logic        clear;
  logic        enter;
  logic        number_ready;
  logic [15:0] number;
  logic        number_valid;
  logic [3:0]  last_digit;
  logic [2:0]  digit_count;
  logic        overflow;

  int checks;
  int errors;

  uint16_number_entry #(.MAX_DIGITS(5)) dut (
    .clk(clk), .rst(rst),
    .zero(keys[0]), .one(keys[1]), .two(keys[2]), .three(keys[3]), .four(keys[4]),
    .five(keys[5]), .six(keys[6]), .seven(keys[7]), .eight(keys[8]), .nine(keys[9]),
    .clear(clear), .enter(enter), .number_ready(number_ready),
    .number(number), .number_valid(number_valid), .last_digit(last_digit),
    .digit_count(digit_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] n, input logic v,
                         input logic [3:0] ld, input logic [2:0] dc, input logic ov);
    chk({tag, ".number"}, 32'(number), 32'(n));
    chk({tag, ".valid"}, 32'(number_valid), 32'(v));
    chk({tag, ".last"}, 32'(last_digit), 32'(ld));
    chk({tag, ".count"}, 32'(digit_count), 32'(dc));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
  endtask

  // press one digit for one cycle, then release for one cycle
  task automatic press(input int d);
    keys = 10'd0;
    keys[d] = 1'b1;
    step();
    keys = 10'd0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    keys = 10'd0;
    clear = 1'b0;
    enter = 1'b0;
    number_ready = 1'b0;
    step();
    step();
    chk_all("reset", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);
    rst = 1'b0;
    step();

    // 4, 2, 7 then enter and delayed ready
    keys[4] = 1'b1;
    step();
    chk_all("d4", 16'd4, 1'b0, 4'd4, 3'd1, 1'b0);
    keys = 10'd0;
    step();
    press(2);
    press(7);
    chk_all("d427", 16'd427, 1'b0, 4'd7, 3'd3, 1'b0);
    enter = 1'b1;
    step();
    enter = 1'b0;
    chk_all("enter", 16'd427, 1'b1, 4'd7, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.valid", 32'(number_valid), 32'd1);
      chk("hold.number", 32'(number), 32'd427);
    end
    number_ready = 1'b1;
    step();
    number_ready = 1'b0;
    chk_all("handoff", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);
    step();

    // 65535 then a sixth digit
    press(6); press(5); press(5); press(3); press(5);
    chk_all("max", 16'd65535, 1'b0, 4'd5, 3'd5, 1'b0);
    press(6);
    chk_all("count_rej", 16'd65535, 1'b0, 4'd5, 3'd5, 1'b1);
    do_clear();
    chk_all("clr1", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);

    // 6553 then 6 exceeds range
    press(6); press(5); press(5); press(3); press(6);
    chk_all("range_rej", 16'd6553, 1'b0, 4'd3, 3'd4, 1'b1);
    do_clear();

    // leading zeros suppressed
    press(0);
    chk_all("lead0", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);
    press(0);
    press(8);
    chk_all("d8", 16'd8, 1'b0, 4'd8, 3'd1, 1'b0);
    do_clear();

    // held key does not repeat; two keys ignored
    keys[3] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    keys = 10'd0;
    step();
    chk_all("held3", 16'd3, 1'b0, 4'd3, 3'd1, 1'b0);
    keys[3] = 1'b1;
    keys[5] = 1'b1;
    step();
    keys = 10'd0;
    step();
    chk_all("multi", 16'd3, 1'b0, 4'd3, 3'd1, 1'b0);
    press(4);
    chk_all("d34", 16'd34, 1'b0, 4'd4, 3'd2, 1'b0);
    do_clear();

    // clear beats a simultaneous digit
    press(1); press(2);
    chk("d12", 32'(number), 32'd12);
    clear = 1'b1;
    keys[9] = 1'b1;
    step();
    chk_all("clr_dig", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);
    clear = 1'b0;
    keys = 10'd0;
    step();

    // enter with no digits is ignored
    enter = 1'b1;
    step();
    enter = 1'b0;
    chk("enter0.valid", 32'(number_valid), 32'd0);
    step();

    // enter ignored in DONE, clear drops valid
    press(5);
    enter = 1'b1;
    step();
    enter = 1'b0;
    step();
    chk("done.valid", 32'(number_valid), 32'd1);
    enter = 1'b1;
    keys[9] = 1'b1;
    step();
    enter = 1'b0;
    keys = 10'd0;
    step();
    chk_all("done_keys", 16'd5, 1'b1, 4'd5, 3'd1, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all("done_clr", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);
    step();

    // async reset mid-entry; held key not accepted until released
    press(3); press(1);
    chk("d31", 32'(number), 32'd31);
    rst = 1'b1;
    #1;
    chk_all("rst_entry", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);
    keys[7] = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    chk_all("rst_held", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);
    keys = 10'd0;
    step();
    press(2);
    chk_all("after_rst", 16'd2, 1'b0, 4'd2, 3'd1, 1'b0);

    // async reset during DONE
    enter = 1'b1;
    step();
    enter = 1'b0;
    chk("pre_rst.valid", 32'(number_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_all("rst_done", 16'd0, 1'b0, 4'd0, 3'd0, 1'b0);
    step();
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uint16_number_entry.md
# uint16_number_entry

Keypad number-entry controller that builds an unsigned 16-bit value from decimal key presses, one digit per press, most significant digit first. Sits between the raw keypad bits and the downstream consumer of the entered number. It owns the accumulator and applies edge detection, multi-key rejection, range checking and digit-count limits. It also drives the last accepted digit to the seven-segment digit display and hands the finished number off with a valid/ready handshake.

## Interface
- MAX_DIGITS, 5, maximum accepted digits (1..5); further digit presses are rejected.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- zero, one, two, three, four, five, six, seven, eight, nine  in  1 each  digit keys, level, held while pressed.
- clear  in  1  level; discards the entry in progress.
- enter  in  1  level; commits the entry.
- number_ready  in  1  consumer accepts number when high with number_valid.
- number  out  16  accumulator value, live during entry, frozen while number_valid.
- number_valid  out  1  committed number available.
- last_digit  out  4  last accepted digit 0..9, for the display; 0 after reset/clear/handoff.
- digit_count  out  3  digits accepted so far, 0..MAX_DIGITS.
- overflow  out  1  sticky: a digit was rejected for range or count.

## Operation
- States: ENTRY, RELEASE (wait until all keys released), DONE (holding committed number).
- Key event: `any_key` is the OR of all ten digit keys plus clear and enter. An event occurs when `any_key` rises (the previous cycle was all-low) while in ENTRY.
- Single digit key at the event, no clear/enter:
  - candidate = number*10 + d, computed 20 bits wide, no truncation.
  - Digit 0 with digit_count==0: no leading zero; nothing changes and no overflow.
  - If candidate > 65535 or digit_count==MAX_DIGITS: reject the digit, set overflow, leave number and digit_count unchanged.
  - Otherwise: number <= candidate[15:0], digit_count += 1, last_digit <= d.
  - Next state RELEASE in all three cases.
- Two or more digit keys at the event: ignored, next state RELEASE.
- enter at the event:
  - digit_count>0: commit, go to DONE.
  - digit_count==0: ignored, go to RELEASE.
- clear: priority over everything, in every state including DONE and RELEASE.
  - Zero number, digit_count, last_digit and overflow; drop number_valid.
  - Next state RELEASE.
- Priority at one event: clear > enter > digit keys.
- RELEASE: stay until any_key is low, then go to ENTRY. Holding a key never repeats the action.
- DONE:
  - number_valid=1; number, last_digit and overflow are held; keys other than clear are ignored.
  - On number_valid && number_ready: zero number, digit_count, last_digit and overflow, then go to RELEASE. RELEASE returns to ENTRY at once if no key is held.

## Timing
- Reset values: state RELEASE, number 0, number_valid 0, last_digit 0, digit_count 0, overflow 0. Reset is effective immediately, mid-entry or mid-handoff.
- Digit accepted: number, digit_count and last_digit update on the clock edge that samples the key rise, so they are visible 1 cycle after the key is first seen high.
- enter sampled high at edge N: number_valid high after edge N.
- Handshake: number_valid stays high until the edge where number_ready is high; it drops after that edge. number_ready with number_valid low has no effect.
- clear sampled at edge N: all outputs are zero after edge N, in any state.
- Consecutive digits require at least one cycle with all keys low between presses.

## Test plan
- Reset, press 4, 2, 7 with release gaps, then enter, with number_ready low for 3 cycles then high -> number 427, digit_count 3, last_digit 7; number_valid held 3+ cycles, drops after the ready edge; outputs then 0.
- Enter 6,5,5,3,5 then 6 -> number 65535, digit_count 5, overflow 1. Alternatively 6,5,5,3,6 -> last digit rejected, number 6553, overflow 1.
- Press 0, then 0, then 8 -> number 8, digit_count 1, no overflow.
- Hold 3 for 10 cycles -> number 3 only. Press 3+5 together -> no change, returns to ENTRY after release.
- Enter 12, press clear and 9 simultaneously -> number 0, digit_count 0, overflow 0. Enter in DONE is ignored; clear in DONE drops number_valid.
- Assert rst mid-entry (number 31) and during DONE -> all outputs 0 immediately; a held key after reset is not accepted until released.
